instr_fetch_assembler: RTL and testbench

INSTR_FETCH_ASSEMBLER -- requirements
Module: instr_fetch_assembler

---
 rtl/instr_fetch_assembler_pkg.sv | 21 ++
 rtl/instr_fetch_assembler_length.sv | 21 ++
 rtl/instr_fetch_assembler.sv | 170 +++++++++++++++++
 tb/tb_instr_fetch_assembler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_assembler_pkg.sv
// Shared definitions for the byte-serial instruction fetch/assembly slice:
// FSM state encoding, opcode length-field position and the length clamp.
package instr_fetch_assembler_pkg;

  typedef enum logic [1:0] {
    OPCODE  = 2'b00,
    OPERAND = 2'b01,
    STALL   = 2'b10
  } fetch_state_t;

  localparam int LEN_FIELD_LSB = 3;
  localparam int LEN_FIELD_MSB = 4;

  // Opcodes may ask for more operand bytes than the output word can hold.
  function automatic logic [1:0] clamp_extra(input logic [1:0] raw, input int max_bytes);
    if ((max_bytes - 1) < int'(raw))
      return 2'(max_bytes - 1);
    return raw;
  endfunction

endpackage

// File: rtl/instr_fetch_assembler_length.sv
// Opcode length decode: extra operand bytes from the opcode length field,
// clamped to the output width, plus total length in bytes.
module instr_length_decoder
  import instr_fetch_assembler_pkg::*;
#(
  parameter int BYTE_W    = 8,
  parameter int MAX_BYTES = 4
) (
  input  logic [BYTE_W-1:0] opcode,
  output logic [1:0]        extra,
  output logic [3:0]        length
);

  logic unused_opcode_bits;

  assign extra  = clamp_extra(opcode[LEN_FIELD_MSB:LEN_FIELD_LSB], MAX_BYTES);
  assign length = {2'b00, extra} + 4'd1;

  assign unused_opcode_bits = ^{opcode[BYTE_W-1:LEN_FIELD_MSB+1], opcode[LEN_FIELD_LSB-1:0]};

endmodule

// File: rtl/instr_fetch_assembler.sv
// Fetches one ROM byte per cycle, assembles variable-length instructions
// (opcode in the MS byte) and presents them on a valid/ready output register.
module instr_fetch_assembler
  import instr_fetch_assembler_pkg::*;
#(
  parameter int BYTE_W     = 8,
  parameter int MAX_BYTES  = 4,
  parameter int ADDR_W     = 9,
  parameter int START_ADDR = 0,
  parameter int ADDR_STEP  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [BYTE_W-1:0]           mem_rdata,
  input  logic                        jump_valid,
  input  logic [ADDR_W-1:0]           jump_addr,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MAX_BYTES*BYTE_W-1:0] out_data,
  output logic [3:0]                  out_len,
  output logic [15:0]                 instr_count
);

  localparam int DATA_W = MAX_BYTES * BYTE_W;
  localparam logic [2:0] FIRST_OPND_POS = (MAX_BYTES >= 2) ? 3'(MAX_BYTES - 2) : 3'd0;

  fetch_state_t      state_reg, state_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic [2:0]        pos_reg, pos_next;
  logic [DATA_W-1:0] asm_reg, asm_next;
  logic [3:0]        asm_len_reg, asm_len_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic [3:0]        out_len_reg, out_len_next;
  logic [15:0]       count_reg, count_next;

  logic [1:0]           dec_extra;
  logic [3:0]           dec_len;
  logic [MAX_BYTES-1:0] slot_sel;
  logic                 transfer;
  logic                 out_free;
  logic                 complete;

  instr_length_decoder #(
    .BYTE_W   (BYTE_W),
    .MAX_BYTES(MAX_BYTES)
  ) u_len_dec (
    .opcode(mem_rdata),
    .extra (dec_extra),
    .length(dec_len)
  );

  // Operand bytes fill the assembly word from just below the opcode downwards.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_BYTES; gi++) begin : g_slot
      assign slot_sel[gi] = (pos_reg == 3'(gi));
    end
  endgenerate

  assign transfer = out_valid_reg && out_ready;
  assign out_free = !out_valid_reg || out_ready;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pos_next       = pos_reg;
    asm_next       = asm_reg;
    asm_len_next   = asm_len_reg;
    addr_next      = addr_reg;
    out_valid_next = out_valid_reg && !transfer;
    out_data_next  = out_data_reg;
    out_len_next   = out_len_reg;
    count_next     = transfer ? count_reg + 16'd1 : count_reg;
    complete       = 1'b0;

    case (state_reg)
      OPCODE: begin
        addr_next                      = addr_reg + ADDR_W'(ADDR_STEP);
        asm_next                       = '0;
        asm_next[DATA_W-1 -: BYTE_W]   = mem_rdata;
        asm_len_next                   = dec_len;
        if (dec_extra == 2'd0) begin
          complete = 1'b1;
        end else begin
          state_next = OPERAND;
          cnt_next   = dec_extra;
          pos_next   = FIRST_OPND_POS;
        end
      end
      OPERAND: begin
        addr_next = addr_reg + ADDR_W'(ADDR_STEP);
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (slot_sel[i])
            asm_next[i*BYTE_W +: BYTE_W] = mem_rdata;
        end
        cnt_next = cnt_reg - 2'd1;
        pos_next = pos_reg - 3'd1;
        if (cnt_reg == 2'd1)
          complete = 1'b1;
      end
      STALL: begin
        if (out_ready) begin
          out_valid_next = 1'b1;
          out_data_next  = asm_reg;
          out_len_next   = asm_len_reg;
          state_next     = OPCODE;
        end
      end
      default: state_next = OPCODE;
    endcase

    // A finished instruction goes straight out if the output slot frees up.
    if (complete) begin
      if (out_free) begin
        out_valid_next = 1'b1;
        out_data_next  = asm_next;
        out_len_next   = asm_len_next;
        state_next     = OPCODE;
      end else begin
        state_next = STALL;
      end
    end

    if (jump_valid) begin
      state_next     = OPCODE;
      cnt_next       = 2'd0;
      pos_next       = 3'd0;
      asm_next       = '0;
      asm_len_next   = 4'd0;
      addr_next      = jump_addr;
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= OPCODE;
      cnt_reg       <= 2'd0;
      pos_reg       <= 3'd0;
      asm_reg       <= '0;
      asm_len_reg   <= 4'd0;
      addr_reg      <= ADDR_W'(START_ADDR);
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_len_reg   <= 4'd0;
      count_reg     <= 16'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pos_reg       <= pos_next;
      asm_reg       <= asm_next;
      asm_len_reg   <= asm_len_next;
      addr_reg      <= addr_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_len_reg   <= out_len_next;
      count_reg     <= count_next;
    end
  end

  assign mem_addr    = addr_reg;
  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_len     = out_len_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_instr_fetch_assembler.sv
// Self-checking bench: directed scenarios plus randomized ROM/backpressure
// checked against an address-walking instruction model.
module tb_instr_fetch_assembler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jump_valid = 1'b0;
  logic [8:0]  jump_addr = '0;
  logic        out_ready = 1'b0;

  logic [8:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_len;
  logic [15:0] instr_count;

  logic [8:0]  mem_addr2;
  logic [7:0]  mem_rdata2;
  logic        out_valid2;
  logic [15:0] out_data2;
  logic [3:0]  out_len2;
  logic [15:0] instr_count2;

  logic [7:0] rom  [512];
  logic [7:0] rom2 [512];

  int checks = 0;
  int failures = 0;

  logic [31:0] got_data[$];
  logic [3:0]  got_len[$];
  logic [31:0] exp_data[$];
  logic [3:0]  exp_len[$];

  always #5 clk = ~clk;

  assign mem_rdata  = rom[mem_addr];
  assign mem_rdata2 = rom2[mem_addr2];

  instr_fetch_assembler dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_len(out_len),
    .instr_count(instr_count)
  );

  instr_fetch_assembler #(.MAX_BYTES(2)) dut2 (
    .clk(clk), .reset(reset), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2),
    .jump_valid(jump_valid), .jump_addr(jump_addr), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_len(out_len2),
    .instr_count(instr_count2)
  );

  // Transfers of the main instance, sampled on the falling edge before they happen.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_len.push_back(out_len);
    end
  end

  task automatic clear_roms();
    for (int i = 0; i < 512; i++) begin
      rom[i]  = 8'h00;
      rom2[i] = 8'h00;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    got_data.delete();
    got_len.delete();
  endtask

  // Reference: walk the ROM from start, splitting it into instructions by the length rule.
  task automatic build_model(input int start, input int n, input int max_bytes);
    int a;
    int extra;
    logic [7:0]  op;
    logic [31:0] d;
    exp_data.delete();
    exp_len.delete();
    a = start;
    for (int k = 0; k < n; k++) begin
      op = rom[a];
      extra = int'(op[4:3]);
      if (extra > max_bytes - 1) extra = max_bytes - 1;
      d = '0;
      for (int b = 0; b <= extra; b++)
        d[(max_bytes-1-b)*8 +: 8] = rom[(a + b) % 512];
      exp_data.push_back(d);
      exp_len.push_back(4'(extra + 1));
      a = (a + extra + 1) % 512;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (mem_addr !== 9'd0 || out_valid !== 1'b0 || out_data !== 32'd0 ||
        out_len !== 4'd0 || instr_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: addr=%0h valid=%b data=%h len=%0d cnt=%0d, required 0/0/0/0/0",
               mem_addr, out_valid, out_data, out_len, instr_count);
    end
    checks++;
    if (mem_addr2 !== 9'd0 || out_valid2 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state2: addr=%0h valid=%b, required 0/0", mem_addr2, out_valid2);
    end
    $display("test_reset: addr=%0h valid=%b cnt=%0d", mem_addr, out_valid, instr_count);
  endtask

  task automatic test_four_byte();
    clear_roms();
    rom[0] = 8'h18; rom[1] = 8'hAA; rom[2] = 8'hBB; rom[3] = 8'hCC;
    out_ready = 1'b1;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h18AABBCC || out_len !== 4'd4) begin
      failures++;
      $display("FAIL four_byte: valid=%b data=%h len=%0d, required 1 18aabbcc 4",
               out_valid, out_data, out_len);
    end
    checks++;
    if (mem_addr !== 9'd4) begin
      failures++;
      $display("FAIL four_byte_addr: addr=%0h, required 4", mem_addr);
    end
    $display("test_four_byte: data=%h len=%0d addr=%0h", out_data, out_len, mem_addr);
  endtask

  task automatic test_short_instrs();
    clear_roms();
    rom[0] = 8'h00; rom[1] = 8'h08; rom[2] = 8'h55; rom[3] = 8'h00;
    out_ready = 1'b1;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (got_data.size() < 2) begin
      failures++;
      $display("FAIL short_count_q: transfers=%0d, required 2", got_data.size());
    end else begin
      if (got_data[0] !== 32'h0 || got_len[0] !== 4'd1) begin
        failures++;
        $display("FAIL short_first: data=%h len=%0d, required 00000000 1", got_data[0], got_len[0]);
      end
      checks++;
      if (got_data[1] !== 32'h08550000 || got_len[1] !== 4'd2) begin
        failures++;
        $display("FAIL short_second: data=%h len=%0d, required 08550000 2", got_data[1], got_len[1]);
      end
    end
    checks++;
    if (instr_count !== 16'd2) begin
      failures++;
      $display("FAIL short_instr_count: cnt=%0d, required 2", instr_count);
    end
    $display("test_short_instrs: transfers=%0d cnt=%0d", got_data.size(), instr_count);
  endtask

  task automatic test_max_bytes2();
    clear_roms();
    rom2[0] = 8'h18; rom2[1] = 8'h77; rom2[2] = 8'h00;
    out_ready = 1'b1;
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid2 !== 1'b1 || out_data2 !== 16'h1877 || out_len2 !== 4'd2) begin
      failures++;
      $display("FAIL max2_data: valid=%b data=%h len=%0d, required 1 1877 2",
               out_valid2, out_data2, out_len2);
    end
    checks++;
    if (mem_addr2 !== 9'd2) begin
      failures++;
      $display("FAIL max2_addr: addr=%0h, required 2", mem_addr2);
    end
    $display("test_max_bytes2: data=%h len=%0d addr=%0h", out_data2, out_len2, mem_addr2);
  endtask

  task automatic test_stall();
    clear_roms();
    out_ready = 1'b0;
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || mem_addr !== 9'd2 || instr_count !== 16'd0) begin
      failures++;
      $display("FAIL stall_hold: valid=%b addr=%0h cnt=%0d, required 1 2 0",
               out_valid, mem_addr, instr_count);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (instr_count !== 16'd1 || out_valid !== 1'b1 || mem_addr !== 9'd2) begin
      failures++;
      $display("FAIL stall_release1: cnt=%0d valid=%b addr=%0h, required 1 1 2",
               instr_count, out_valid, mem_addr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (instr_count !== 16'd2) begin
      failures++;
      $display("FAIL stall_release2: cnt=%0d, required 2", instr_count);
    end
    $display("test_stall: cnt=%0d addr=%0h", instr_count, mem_addr);
  endtask

  task automatic test_back_to_back();
    clear_roms();
    out_ready = 1'b1;
    do_reset();
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (instr_count !== 16'(k) || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back: cycle=%0d cnt=%0d valid=%b, required %0d 1",
                 k, instr_count, out_valid, k);
      end
    end
    $display("test_back_to_back: cnt=%0d", instr_count);
  endtask

  task automatic test_jump();
    clear_roms();
    rom[0] = 8'h18; rom[1] = 8'hAA; rom[2] = 8'hBB; rom[3] = 8'hCC;
    rom[9'h100] = 8'h08; rom[9'h101] = 8'h33;
    out_ready = 1'b1;
    do_reset();
    @(posedge clk);
    #1;
    jump_valid = 1'b1;
    jump_addr  = 9'h100;
    @(posedge clk);
    #1;
    jump_valid = 1'b0;
    checks++;
    if (mem_addr !== 9'h100 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL jump_redirect: addr=%0h valid=%b, required 100 0", mem_addr, out_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h08330000 || out_len !== 4'd2 ||
        instr_count !== 16'd0 || got_data.size() != 0) begin
      failures++;
      $display("FAIL jump_target: valid=%b data=%h len=%0d cnt=%0d q=%0d, required 1 08330000 2 0 0",
               out_valid, out_data, out_len, instr_count, got_data.size());
    end
    $display("test_jump: addr=%0h data=%h", mem_addr, out_data);
  endtask

  task automatic test_reset_mid();
    clear_roms();
    rom[0] = 8'h18; rom[1] = 8'hAA; rom[2] = 8'hBB; rom[3] = 8'hCC;
    out_ready = 1'b1;
    do_reset();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_addr !== 9'd0 || out_valid !== 1'b0 || out_data !== 32'd0 ||
        out_len !== 4'd0 || instr_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_mid_async: addr=%0h valid=%b data=%h len=%0d cnt=%0d, required 0/0/0/0/0",
               mem_addr, out_valid, out_data, out_len, instr_count);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h18AABBCC || out_len !== 4'd4) begin
      failures++;
      $display("FAIL reset_mid_restart: valid=%b data=%h len=%0d, required 1 18aabbcc 4",
               out_valid, out_data, out_len);
    end
    $display("test_reset_mid: data=%h", out_data);
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 512; i++) rom[i] = 8'($urandom_range(0, 255));
    out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    build_model(0, 400, 4);
    n = got_data.size();
    checks++;
    if (n < 20) begin
      failures++;
      $display("FAIL random_progress: transfers=%0d, required >= 20", n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_data[k] !== exp_data[k] || got_len[k] !== exp_len[k]) begin
        failures++;
        $display("FAIL random_instr: idx=%0d data=%h len=%0d, required %h %0d",
                 k, got_data[k], got_len[k], exp_data[k], exp_len[k]);
      end
    end
    checks++;
    if (instr_count !== 16'(n)) begin
      failures++;
      $display("FAIL random_count: cnt=%0d, required %0d", instr_count, n);
    end
    $display("test_random: transfers=%0d cnt=%0d", n, instr_count);
  endtask

  initial begin
    clear_roms();
    test_reset();
    test_four_byte();
    test_short_instrs();
    test_max_bytes2();
    test_stall();
    test_back_to_back();
    test_jump();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
